// File: rtl/pwm_mmio_core.sv
// Multi-channel PWM slot for mmio_sys: prescaler, shared period counter, and per-channel
// double-buffered duty registers that reload only at the period wrap.
module pwm_mmio_core #(
    parameter int W = 6,
    parameter int R = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs,
    input  logic          read,
    input  logic          write,
    input  logic [4:0]    addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data,
    output logic [W-1:0]  pwm_out
);

    localparam logic [R-1:0] D_MAX = '1;

    logic [31:0]  dvsr;
    logic [31:0]  q_reg;
    logic         en;
    logic [R-1:0] d_reg;
    logic [R:0]   pending_duty [W];
    logic [R:0]   active_duty  [W];

    logic wr_en;
    logic ctrl_wr;
    logic en_next;
    logic tick;
    logic wrap;

    // Reads are purely address-decoded, so the read strobe carries no information here.
    logic unused_read;
    assign unused_read = read;

    assign wr_en   = cs && write;
    assign ctrl_wr = wr_en && (addr == 5'd1);
    assign en_next = ctrl_wr ? wr_data[0] : en;
    assign tick    = en && (q_reg >= dvsr);
    assign wrap    = tick && (d_reg == D_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            dvsr <= '0;
            en   <= 1'b0;
            for (int unsigned i = 0; i < W; i++) begin
                pending_duty[i] <= '0;
                active_duty[i]  <= '0;
            end
        end else begin
            if (wr_en && (addr == 5'd0))
                dvsr <= wr_data;
            en <= en_next;
            for (int unsigned i = 0; i < W; i++) begin
                if (wr_en && (addr == 5'(16 + i)))
                    pending_duty[i] <= wr_data[R:0];
                // Non-blocking load picks up the pre-write pending value on a coincident write.
                if (wrap)
                    active_duty[i] <= pending_duty[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg   <= '0;
            d_reg   <= '0;
            pwm_out <= '0;
        end else if (!en_next) begin
            // Clearing on the disabling edge itself leaves no partial count behind.
            q_reg   <= '0;
            d_reg   <= '0;
            pwm_out <= '0;
        end else begin
            if (tick) begin
                q_reg <= '0;
                d_reg <= d_reg + 1'b1;
            end else if (en) begin
                q_reg <= q_reg + 32'd1;
            end
            for (int unsigned i = 0; i < W; i++)
                pwm_out[i] <= en && ({1'b0, d_reg} < active_duty[i]);
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            5'd0: rd_data = dvsr;
            5'd1: rd_data = {31'b0, en};
            5'd2: rd_data = {{(32 - R){1'b0}}, d_reg};
            default: begin
                for (int unsigned i = 0; i < W; i++)
                    if (addr == 5'(16 + i))
                        rd_data = {{(31 - R){1'b0}}, pending_duty[i]};
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_mmio_core.sv
// Directed bench for pwm_mmio_core (W=6, R=10): register-map table plus multi-period
// sequences for shadowing, extremes, prescaler, disable and mid-period reset.
module tb_pwm_mmio_core;

    logic        clk;
    logic        reset;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [5:0]  pwm_out;

    int checks = 0;
    int errors = 0;

    pwm_mmio_core #(.W(6), .R(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .pwm_out (pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string       name;
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(posedge clk);
        #1;
        cs = 1'b0; write = 1'b0; wr_data = '0;
    endtask

    task automatic check_rd(input string name, input logic [4:0] a, input logic [31:0] exp);
        addr = a;
        read = 1'b1;
        #1;
        check(name, rd_data, exp);
        read = 1'b0;
    endtask

    // Samples one channel for n consecutive cycles, advancing one clock per sample.
    task automatic count_high(input int ch, input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            if (pwm_out[ch]) cnt++;
            step(1);
        end
    endtask

    initial begin
        int cnt;
        int cnt1;
        int cnt2;
        int cnt3;

        cs = 0; read = 0; write = 0; addr = '0; wr_data = '0;
        reset = 1'b1;
        step(2);
        reset = 1'b0;

        // 1: reset state
        check("reset_pwm", 32'(pwm_out), 32'd0);
        check_rd("reset_dvsr", 5'd0, 32'd0);
        check_rd("reset_ctrl", 5'd1, 32'd0);
        check_rd("reset_d", 5'd2, 32'd0);
        check_rd("reset_duty0", 5'd16, 32'd0);
        step(1);

        // Register map with en=0 so nothing else moves.
        vecs[0]  = '{"map_dvsr",      1'b1, 5'd0,  32'h1234_5678, 32'h1234_5678};
        vecs[1]  = '{"map_ctrl_bit0", 1'b1, 5'd1,  32'hFFFF_FFFE, 32'd0};
        vecs[2]  = '{"map_d_ro",      1'b1, 5'd2,  32'h0000_0055, 32'd0};
        vecs[3]  = '{"map_duty0_msk", 1'b1, 5'd16, 32'hFFFF_FFFF, 32'h0000_07FF};
        vecs[4]  = '{"map_duty5",     1'b1, 5'd21, 32'h0000_03FF, 32'h0000_03FF};
        vecs[5]  = '{"map_duty6_na",  1'b1, 5'd22, 32'h0000_0123, 32'd0};
        vecs[6]  = '{"map_addr5",     1'b1, 5'd5,  32'hFFFF_FFFF, 32'd0};
        vecs[7]  = '{"map_addr31",    1'b1, 5'd31, 32'h0000_0001, 32'd0};
        vecs[8]  = '{"map_dvsr_keep", 1'b0, 5'd0,  32'd0,         32'h1234_5678};
        vecs[9]  = '{"map_duty0_keep",1'b0, 5'd16, 32'd0,         32'h0000_07FF};
        vecs[10] = '{"map_ctrl_keep", 1'b0, 5'd1,  32'd0,         32'd0};
        vecs[11] = '{"map_d_keep",    1'b0, 5'd2,  32'd0,         32'd0};
        vecs[12] = '{"map_dvsr_clr",  1'b1, 5'd0,  32'd0,         32'd0};
        vecs[13] = '{"map_duty0_256", 1'b1, 5'd16, 32'd256,       32'd256};
        vecs[14] = '{"map_duty5_clr", 1'b1, 5'd21, 32'd0,         32'd0};
        vecs[15] = '{"map_addr3",     1'b0, 5'd3,  32'd0,         32'd0};
        for (int v = 0; v < 16; v++) begin
            if (vecs[v].wr) bus_write(vecs[v].addr, vecs[v].wdata);
            check_rd(vecs[v].name, vecs[v].addr, vecs[v].exp_rd);
            check({vecs[v].name, "_pwm"}, 32'(pwm_out), 32'd0);
            step(1);
        end

        // 2: basic duty, dvsr=0. Enabling edge is E0; d after Ek = k mod 1024.
        bus_write(5'd1, 32'd1);
        step(1);
        check_rd("basic_d_after_e1", 5'd2, 32'd1);
        step(1023);
        check_rd("basic_d_wrap", 5'd2, 32'd0);
        check("basic_pwm0_before", 32'(pwm_out[0]), 32'd0);
        step(1);
        check("basic_pwm0_first", 32'(pwm_out[0]), 32'd1);
        count_high(0, 1024, cnt);
        check("basic_high_256", 32'(cnt), 32'd256);
        check("basic_other_ch", 32'(pwm_out[5:1]), 32'd0);

        // 3: shadowing. Now after E2049 (d=1).
        step(399);
        check_rd("shadow_d_400", 5'd2, 32'd400);
        bus_write(5'd16, 32'd512);
        check_rd("shadow_readback", 5'd16, 32'd512);
        step(11);
        check("shadow_old_duty", 32'(pwm_out[0]), 32'd0);
        step(613);
        count_high(0, 1024, cnt);
        check("shadow_high_512", 32'(cnt), 32'd512);
        step(1022);
        check_rd("shadow_d_1023", 5'd2, 32'd1023);
        bus_write(5'd16, 32'd100);
        step(1);
        count_high(0, 1024, cnt);
        check("wrapwrite_still_512", 32'(cnt), 32'd512);
        count_high(0, 1024, cnt);
        check("wrapwrite_now_100", 32'(cnt), 32'd100);

        // 4: extremes. Now after E7169.
        bus_write(5'd18, 32'd1024);
        bus_write(5'd19, 32'd2047);
        check_rd("ext_rd18", 5'd18, 32'd1024);
        check_rd("ext_rd19", 5'd19, 32'd2047);
        step(1022);
        cnt1 = 0; cnt2 = 0; cnt3 = 0;
        for (int k = 0; k < 1024; k++) begin
            if (pwm_out[1]) cnt1++;
            if (pwm_out[2]) cnt2++;
            if (pwm_out[3]) cnt3++;
            step(1);
        end
        check("ext_duty0_never", 32'(cnt1), 32'd0);
        check("ext_duty1024_always", 32'(cnt2), 32'd1024);
        check("ext_duty2047_always", 32'(cnt3), 32'd1024);

        // 6a: disable mid-period (d=500).
        step(499);
        check_rd("dis_d_500", 5'd2, 32'd500);
        bus_write(5'd1, 32'd0);
        check_rd("dis_d_zero", 5'd2, 32'd0);
        check("dis_pwm_zero", 32'(pwm_out), 32'd0);
        check_rd("dis_duty_kept", 5'd16, 32'd100);
        step(5);
        check_rd("dis_d_hold", 5'd2, 32'd0);

        // 5: prescaler. Enabling edge is F0.
        bus_write(5'd0, 32'd3);
        bus_write(5'd1, 32'd1);
        step(1);
        check("reen_pwm_active", 32'(pwm_out), 32'b001101);
        check_rd("pre_d_f1", 5'd2, 32'd0);
        step(2);
        check_rd("pre_d_f3", 5'd2, 32'd0);
        step(1);
        check_rd("pre_d_f4", 5'd2, 32'd1);
        step(3);
        check_rd("pre_d_f7", 5'd2, 32'd1);
        step(1);
        check_rd("pre_d_f8", 5'd2, 32'd2);
        step(2);
        bus_write(5'd0, 32'd1);
        check_rd("pre_d_f11", 5'd2, 32'd2);
        step(1);
        check_rd("pre_lower_tick", 5'd2, 32'd3);
        step(1);
        check_rd("pre_d_f13", 5'd2, 32'd3);
        step(1);
        check_rd("pre_d_f14", 5'd2, 32'd4);
        step(2);
        check_rd("pre_d_f16", 5'd2, 32'd5);

        // 6b: unmapped write leaves state alone.
        bus_write(5'd5, 32'hFFFF_FFFF);
        check_rd("unm_rd5", 5'd5, 32'd0);
        check_rd("unm_dvsr", 5'd0, 32'd1);
        check_rd("unm_ctrl", 5'd1, 32'd1);
        check_rd("unm_duty2", 5'd18, 32'd1024);
        step(1);

        // 6c: reset mid-period.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check_rd("rst_dvsr", 5'd0, 32'd0);
        check_rd("rst_ctrl", 5'd1, 32'd0);
        check_rd("rst_d", 5'd2, 32'd0);
        check_rd("rst_duty0", 5'd16, 32'd0);
        step(3);
        check_rd("rst_d_hold", 5'd2, 32'd0);
        check("rst_pwm_hold", 32'(pwm_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
